// File: rtl/image_window_buffer_if.sv
// Pixel load stream and window output stream between loader, image buffer and MAC.
interface image_window_buffer_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     mem_ok;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_first;
    logic                     out_last;

    modport master (
        output in_valid, in_data, mem_ok, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, mem_ok, out_ready,
        output in_ready, out_valid, out_data, out_first, out_last
    );
endinterface

// File: rtl/image_window_buffer.sv
// Stores one IMG_W x IMG_H image, then replays every K x K stride-1 window
// as a serial back-pressured pixel stream.
module image_window_buffer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    image_window_buffer_if.slave  bus,
    input  logic                  start,
    input  logic                  reload,
    output logic                  loaded,
    output logic                  busy,
    output logic                  done
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] K_MAX   = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] C_MAX   = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] R_MAX   = ADDR_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] ROW     = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] r, c, kr, kc;
    logic [ADDR_W-1:0] rd_addr;
    logic              more;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en, wr_last, go, take, load_out, finish, at_end;

    assign wr_en    = (state == S_LOAD) && bus.in_valid && bus.mem_ok;
    assign wr_last  = wr_en && (wr_ptr == LAST_WR);
    assign go       = (state == S_READY) && start && !reload;
    assign take     = bus.out_valid && bus.out_ready;
    assign load_out = go || ((state == S_STREAM) && more && (!bus.out_valid || bus.out_ready));
    assign finish   = (state == S_STREAM) && take && !more;
    assign at_end   = (kc == K_MAX) && (kr == K_MAX) && (c == C_MAX) && (r == R_MAX);
    assign rd_addr  = (r + kr) * ROW + c + kc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nx;
    end

    // NOTE: defaulting every combinational output first keeps unlisted
    // branches from inferring latches.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_LOAD:   if (wr_last) state_nx = S_READY;
            S_READY:  if (reload) state_nx = S_LOAD;
                      else if (start) state_nx = S_STREAM;
            S_STREAM: if (finish) state_nx = S_READY;
            default:  state_nx = S_LOAD;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == S_LOAD);
        loaded       = (state != S_LOAD);
        busy         = (state == S_STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if ((state == S_READY) && reload) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        end
    end

    // NOTE: image storage has no reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.in_data;
    end

    // Window walker: counters always point at the next pixel to emit and
    // wrap back to zero after the final window, ready for the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            c    <= '0;
            kr   <= '0;
            kc   <= '0;
            more <= 1'b0;
        end else if (load_out) begin
            more <= !at_end;
            if (kc != K_MAX) begin
                kc <= kc + 1'b1;
            end else begin
                kc <= '0;
                if (kr != K_MAX) begin
                    kr <= kr + 1'b1;
                end else begin
                    kr <= '0;
                    if (c != C_MAX) begin
                        c <= c + 1'b1;
                    end else begin
                        c <= '0;
                        r <= (r != R_MAX) ? r + 1'b1 : '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= finish;
            if (load_out) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= mem[rd_addr];
                bus.out_first <= (kr == '0) && (kc == '0);
                bus.out_last  <= (kr == K_MAX) && (kc == K_MAX);
            end else if (finish) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_image_window_buffer.sv
// Checks a K=3 and a K=1 buffer (4x4 image) against a window-enumerating model.
module tb_image_window_buffer;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, mem_ok = 1'b0, start = 1'b0, reload = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          loaded0, busy0, done0, loaded1, busy1, done1;

    image_window_buffer_if #(.DATA_W(DW)) b0 ();
    image_window_buffer_if #(.DATA_W(DW)) b1 ();

    assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
    assign b0.in_data  = in_data;   assign b1.in_data  = in_data;
    assign b0.mem_ok   = mem_ok;    assign b1.mem_ok   = mem_ok;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;

    image_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(3), .ADDR_W(AW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave), .start(start), .reload(reload),
        .loaded(loaded0), .busy(busy0), .done(done0));

    image_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave), .start(start), .reload(reload),
        .loaded(loaded1), .busy(busy1), .done(done1));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Behavioural model: image array plus a precomputed list of window pixels.
    typedef enum {M_LOAD, M_READY, M_STREAM} mst_t;
    mst_t mst [2];
    int   img [2][16];
    int   wcnt [2];
    int   exp_d [2][36];
    bit   exp_f [2][36];
    bit   exp_l [2][36];
    int   exp_len [2];
    int   idx [2];
    bit   done_exp [2];
    int   cap_d [2][36];
    bit   cap_f [2][36];
    bit   cap_l [2][36];
    int   cap_n [2];
    int   done_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin : per_dut
            logic ov, of, ol, ir, ld, bz, dn;
            logic [DW-1:0] od;
            string pf;
            int k, n;
            pf = (d == 0) ? "k3" : "k1";
            k  = (d == 0) ? 3 : 1;
            ov = (d == 0) ? b0.out_valid : b1.out_valid;
            of = (d == 0) ? b0.out_first : b1.out_first;
            ol = (d == 0) ? b0.out_last  : b1.out_last;
            od = (d == 0) ? b0.out_data  : b1.out_data;
            ir = (d == 0) ? b0.in_ready  : b1.in_ready;
            ld = (d == 0) ? loaded0 : loaded1;
            bz = (d == 0) ? busy0   : busy1;
            dn = (d == 0) ? done0   : done1;
            if (!rst_n) begin
                mst[d]      = M_LOAD;
                wcnt[d]     = 0;
                done_exp[d] = 1'b0;
            end else begin
                check({pf, ".in_ready"},  ir, mst[d] == M_LOAD);
                check({pf, ".loaded"},    ld, mst[d] != M_LOAD);
                check({pf, ".busy"},      bz, mst[d] == M_STREAM);
                check({pf, ".done"},      dn, done_exp[d]);
                check({pf, ".out_valid"}, ov, mst[d] == M_STREAM);
                if (ov && mst[d] == M_STREAM && idx[d] < exp_len[d]) begin
                    check({pf, ".out_data"},  od, exp_d[d][idx[d]]);
                    check({pf, ".out_first"}, of, exp_f[d][idx[d]]);
                    check({pf, ".out_last"},  ol, exp_l[d][idx[d]]);
                end
                if (ov && out_ready && cap_n[d] < 36) begin
                    cap_d[d][cap_n[d]] = int'(od);
                    cap_f[d][cap_n[d]] = of;
                    cap_l[d][cap_n[d]] = ol;
                    cap_n[d]++;
                end
                if (dn) done_cnt[d]++;
                done_exp[d] = 1'b0;
                case (mst[d])
                    M_LOAD: if (in_valid && mem_ok) begin
                        img[d][wcnt[d]] = int'(in_data);
                        wcnt[d]++;
                        if (wcnt[d] == W * H) begin
                            mst[d]  = M_READY;
                            wcnt[d] = 0;
                        end
                    end
                    M_READY: if (reload) begin
                        mst[d]  = M_LOAD;
                        wcnt[d] = 0;
                    end else if (start) begin
                        n = 0;
                        for (int r = 0; r <= H - k; r++)
                            for (int c = 0; c <= W - k; c++)
                                for (int kr = 0; kr < k; kr++)
                                    for (int kc = 0; kc < k; kc++) begin
                                        exp_d[d][n] = img[d][(r + kr) * W + c + kc];
                                        exp_f[d][n] = (kr == 0) && (kc == 0);
                                        exp_l[d][n] = (kr == k - 1) && (kc == k - 1);
                                        n++;
                                    end
                        exp_len[d] = n;
                        idx[d]     = 0;
                        cap_n[d]   = 0;
                        mst[d]     = M_STREAM;
                    end
                    M_STREAM: if (out_ready) begin
                        idx[d]++;
                        if (idx[d] == exp_len[d]) begin
                            mst[d]      = M_READY;
                            done_exp[d] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check_reset();
        check("k3.reset_flags", {b0.out_valid, b0.out_first, b0.out_last, b0.in_ready, loaded0, busy0, done0}, 7'b0001000);
        check("k1.reset_flags", {b1.out_valid, b1.out_first, b1.out_last, b1.in_ready, loaded1, busy1, done1}, 7'b0001000);
        check("k3.reset_data", b0.out_data, 0);
        check("k1.reset_data", b1.out_data, 0);
    endtask

    task automatic beat(input int data, input bit valid, input bit ok);
        in_valid = valid;
        mem_ok   = ok;
        in_data  = DW'(data);
        @(posedge clk); #1;
    endtask

    task automatic load(input int base, input bit with_bad, input bit start_mid);
        for (int i = 0; i < W * H; i++) begin
            if (with_bad && (i % 3 == 2)) beat(99, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) beat(int'($urandom_range(0, 200)), 1'b0, 1'b1);
            if (i == W * H - 1) check("loaded_before_last", {loaded0, loaded1}, 2'b00);
            start = start_mid && (i == 3);
            beat(base + i, 1'b1, 1'b1);
            start = 1'b0;
        end
        beat(77, 1'b1, 1'b1);
        in_valid = 1'b0;
        mem_ok   = 1'b0;
        check("loaded_after_last", {loaded0, loaded1}, 2'b11);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check("reload_to_load", {b0.in_ready, b1.in_ready, loaded0, loaded1}, 4'b1100);
    endtask

    // mode 0: ready high; 1: random ready with a stall on out_last;
    // 2: ready high plus start/reload pulses mid-stream; 3: reset after pixel 12
    task automatic run(input int mode);
        int dc0 = done_cnt[0];
        int dc1 = done_cnt[1];
        bit stalled = 1'b0;
        bit fin = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_latency", {b0.out_valid, b1.out_valid, busy0, busy1}, 4'hf);
        for (int n = 0; n < 400 && !fin; n++) begin
            if (mode == 1) begin
                if (b0.out_valid && b0.out_last && !stalled) begin
                    out_ready = 1'b0;
                    stalled = 1'b1;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            start  = (mode == 2) && (n == 4);
            reload = (mode == 2) && (n == 4);
            if (mode == 3 && cap_n[0] >= 13) begin
                rst_n = 1'b0;
                #1;
                check_reset();
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                fin = (done_cnt[0] > dc0) && (done_cnt[1] > dc1);
            end
        end
        start = 1'b0;
        reload = 1'b0;
        out_ready = 1'b1;
        check("run_timeout", fin, 1'b1);
        if (mode == 3) begin
            repeat (2) @(posedge clk);
            #1;
            check_reset();
            rst_n = 1'b1;
        end else begin
            check("k3.done_pulses", done_cnt[0] - dc0, 1);
            check("k1.done_pulses", done_cnt[1] - dc1, 1);
        end
    endtask

    task automatic lit3(input int base);
        int w1 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        check("k3.count", cap_n[0], 36);
        for (int i = 0; i < 9; i++) begin
            check("k3.window0", cap_d[0][i], base + w1[i]);
            check("k3.window1", cap_d[0][9 + i], base + w1[i] + 1);
            check("k3.window3", cap_d[0][27 + i], base + w1[i] + 5);
        end
        for (int i = 0; i < 36; i++) begin
            check("k3.first_pos", cap_f[0][i], (i % 9) == 0);
            check("k3.last_pos",  cap_l[0][i], (i % 9) == 8);
        end
    endtask

    task automatic lit1(input int base);
        check("k1.count", cap_n[1], 16);
        for (int i = 0; i < 16; i++) begin
            check("k1.pixel", cap_d[1][i], base + i);
            check("k1.first_last", {cap_f[1][i], cap_l[1][i]}, 2'b11);
        end
    endtask

    initial begin
        cap_n   = '{0, 0};
        idx     = '{0, 0};
        exp_len = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        load(0, 1'b0, 1'b0);
        run(0);
        lit3(0);
        lit1(0);

        do_reload();
        load(0, 1'b1, 1'b0);
        run(0);
        lit3(0);
        lit1(0);

        run(1);
        lit3(0);
        lit1(0);

        do_reload();
        load(0, 1'b0, 1'b1);
        run(2);
        lit3(0);
        lit1(0);
        run(0);
        lit3(0);
        lit1(0);
        do_reload();
        load(16, 1'b0, 1'b0);
        run(0);
        lit3(16);
        lit1(16);

        run(3);
        load(0, 1'b0, 1'b0);
        run(0);
        lit3(0);
        lit1(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/image_window_buffer.md
# image_window_buffer

Parametrised image buffer for the CNN datapath. It stores one IMG_W x IMG_H image from a valid/ready stream, gated by `mem_ok`. On `start` it replays every K x K stride-1 convolution window as a serial, back-pressured pixel stream. It replaces the fixed 9-word image RAM with fixed read address, and sits between the memory loader and the convolution MAC.

## Interface
- `DATA_W`, 16, pixel width (signed two's complement)
- `IMG_W`, 28, image width in pixels (K..1024)
- `IMG_H`, 28, image height in pixels (K..1024)
- `K`, 3, window edge (1..IMG_W, 1..IMG_H)
- `ADDR_W`, 10, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  loader word valid
- `in_ready`  out  1  buffer can accept a word
- `in_data`  in  DATA_W  signed pixel, raster order (row-major)
- `mem_ok`  in  1  loader memory qualifier; a write happens only when it is high
- `start`  in  1  single-cycle request to stream all windows
- `reload`  in  1  discard image and return to LOAD
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts `out_data`
- `out_data`  out  DATA_W  signed window pixel
- `out_first`  out  1  first pixel of a window (kr=0, kc=0)
- `out_last`  out  1  last pixel of a window (kr=K-1, kc=K-1)
- `loaded`  out  1  full image stored
- `busy`  out  1  streaming in progress
- `done`  out  1  one-cycle pulse after the final pixel is accepted

## Operation
- RAM: IMG_W*IMG_H words of DATA_W bits, with a registered write and an asynchronous read into the output register. RAM contents are not reset.
- States: LOAD, READY, STREAM. Reset enters LOAD.
- LOAD:
  - `in_ready`=1.
  - When `in_valid & mem_ok`, write `in_data` at `wr_ptr` and increment `wr_ptr`.
  - A word with `mem_ok`=0 is neither written nor counted.
  - When word IMG_W*IMG_H-1 is written, go to READY.
- READY:
  - `loaded`=1, `in_ready`=0.
  - `start` goes to STREAM with origin (r,c)=(0,0) and offset (kr,kc)=(0,0).
  - `reload` clears `wr_ptr` and goes to LOAD.
  - If `start` and `reload` are asserted in the same cycle, `reload` wins.
- STREAM:
  - `busy`=1.
  - Read address is (r+kr)*IMG_W+(c+kc). Maintain it incrementally or by constant multiply; in either case it is ADDR_W bits with no wrap.
  - Iteration order: kc fastest, then kr, then c (0..IMG_W-K), then r (0..IMG_H-K).
  - Total output count is (IMG_H-K+1)*(IMG_W-K+1)*K*K.
- Output register:
  - Loads the next pixel when empty, or when `out_valid & out_ready`.
  - While `out_valid & !out_ready`, `out_data`, `out_first` and `out_last` hold stable.
- After the final pixel handshake:
  - `done` pulses for one cycle, `out_valid` falls and the state returns to READY.
  - The image is retained, so a later `start` replays identical data.
- Ignored inputs:
  - `start` in LOAD or STREAM.
  - `reload` in STREAM.
  - `in_valid` outside LOAD (no write; `in_ready`=0).

## Timing
- Reset values: `in_ready`=1 (LOAD), `out_valid`=0, `out_data`=0, `out_first`=0, `out_last`=0, `loaded`=0, `busy`=0, `done`=0.
- Load throughput is one word per cycle. Word N accepted at edge t gives `loaded`=1 from t+1.
- Latency from `start` to data: `start` sampled at edge t gives `out_valid`=1 with the first pixel from t+1.
- With `out_ready` held high, one pixel per cycle with no bubbles, including across window and row boundaries.
- `busy` is high from t+1 through the cycle holding the final pixel.
- `done` is asserted in the cycle after the final handshake. `busy`=0 and `loaded`=1 in that same cycle.
- Reset mid-LOAD or mid-STREAM applies all reset values immediately (asynchronous); counters clear and the state is LOAD.
- K=IMG_W=IMG_H is a single window. K=1 gives `out_first`=`out_last`=1 on every pixel.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, K=3, ADDR_W=4, with the load stream carrying values 0..15.

1. **Basic load and stream:**
   - Stimulus: load 0..15 with `mem_ok`=1, then `start` with `out_ready`=1.
   - Required response: 36 pixels:
     - first window 0,1,2,4,5,6,8,9,10;
     - second window 1,2,3,5,6,7,9,10,11;
     - last window 5,6,7,9,10,11,13,14,15.
   - `out_first` on pixels 0,9,18,27; `out_last` on 8,17,26,35; `done` one cycle after pixel 35.
2. **`mem_ok` gating:**
   - Stimulus: interleave `mem_ok`=0 on 5 beats carrying 99.
   - Required response: value 99 is never stored, `loaded` rises only after the 16th qualified word, and the stream matches scenario 1.
3. **Back-pressure:**
   - Stimulus: random `out_ready` (50%), including a stall on an `out_last` pixel.
   - Required response: no pixel is lost or duplicated, outputs are stable while stalled, and the sequence matches scenario 1.
4. **Ignored and reload controls:**
   - Stimulus: `start` during LOAD; `start` and `reload` during STREAM.
   - Required response: no effect in either case.
   - Follow-up: after `done`, `start` again gives an identical 36-pixel stream. Then `reload` and load 16..31 gives a first window of 16,17,18,20,21,22,24,25,26.
5. **Reset mid-stream:**
   - Stimulus: assert `rst_n`=0 after pixel 12.
   - Required response: all outputs take reset values immediately and the state is LOAD (`in_ready`=1, `loaded`=0).
   - Follow-up: reload 0..15 and `start` gives the full scenario 1 sequence from pixel 0.
6. **Degenerate window:**
   - Stimulus: K=1.
   - Required response: 16 pixels 0..15 with `out_first`=`out_last`=1 on each.
